// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer and its surroundings:
// run-control and hazard/branch inputs in, PC control and status out.
interface fetch_sequencer_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 start;
  logic                 step;
  logic                 stop;
  logic                 branch_taken;
  logic                 jump_taken;
  logic                 stall;
  logic                 halt_instr;
  logic [1:0]           pc_sel;
  logic                 pc_en;
  logic                 if_flush;
  logic                 pipe_en;
  logic [2:0]           state;
  logic                 halted;
  logic [CNT_WIDTH-1:0] cycle_count;

  modport master (
    output start, step, stop, branch_taken, jump_taken, stall, halt_instr,
    input  pc_sel, pc_en, if_flush, pipe_en, state, halted, cycle_count
  );

  modport slave (
    input  start, step, stop, branch_taken, jump_taken, stall, halt_instr,
    output pc_sel, pc_en, if_flush, pipe_en, state, halted, cycle_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: selects PC source, flush and pipeline enable,
// with debug run control and HALT detection followed by a pipeline drain.
module fetch_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t               stateQ;
  logic [DW-1:0]        drainCnt;
  logic                 haltedQ;
  logic [CNT_WIDTH-1:0] cycleCnt;

  logic [1:0] pcSel;
  logic       pcEn;
  logic       ifFlush;
  logic       pipeEn;
  logic       haltTaken;

  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // PC control is combinational so the PC register sees it with zero latency.
  always_comb begin
    pcSel     = 2'b11;
    pcEn      = 1'b0;
    ifFlush   = 1'b0;
    pipeEn    = 1'b0;
    haltTaken = 1'b0;
    case (stateQ)
      RUN, STEP: begin
        pipeEn = 1'b1;
        if (bus.branch_taken) begin
          pcSel   = 2'b01;
          pcEn    = 1'b1;
          ifFlush = 1'b1;
        end else if (bus.stall) begin
          pcSel = 2'b11;
        end else if (bus.jump_taken) begin
          pcSel   = 2'b10;
          pcEn    = 1'b1;
          ifFlush = 1'b1;
        end else if (bus.halt_instr) begin
          haltTaken = 1'b1;
        end else begin
          pcSel = 2'b00;
          pcEn  = 1'b1;
        end
      end
      DRAIN: begin
        pipeEn = 1'b1;
        // A taken branch means the HALT was fetched down the wrong path.
        if (bus.branch_taken) begin
          pcSel   = 2'b01;
          pcEn    = 1'b1;
          ifFlush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A committed HALT wins over stop so the stages behind IF always drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= IDLE;
      drainCnt <= '0;
      haltedQ  <= 1'b0;
      cycleCnt <= '0;
    end else begin
      if (pipeEn) cycleCnt <= satInc(cycleCnt);
      haltedQ <= (stateQ == HALTED);
      case (stateQ)
        IDLE: begin
          if (bus.start)     stateQ <= RUN;
          else if (bus.step) stateQ <= STEP;
        end
        RUN: begin
          if (haltTaken) begin
            stateQ   <= DRAIN;
            drainCnt <= DW'(DRAIN_CYCLES - 1);
          end else if (bus.stop) begin
            stateQ <= IDLE;
          end
        end
        STEP: begin
          if (haltTaken) begin
            stateQ   <= DRAIN;
            drainCnt <= DW'(DRAIN_CYCLES - 1);
          end else begin
            stateQ <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.branch_taken) begin
            stateQ   <= RUN;
            drainCnt <= '0;
          end else if (!bus.stall) begin
            if (drainCnt == '0) stateQ <= HALTED;
            else                drainCnt <= drainCnt - 1'b1;
          end
        end
        HALTED: ;
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign bus.pc_sel      = pcSel;
  assign bus.pc_en       = pcEn;
  assign bus.if_flush    = ifFlush;
  assign bus.pipe_en     = pipeEn;
  assign bus.state       = stateQ;
  assign bus.halted      = haltedQ;
  assign bus.cycle_count = cycleCnt;

endmodule
